// File: rtl/ram8.sv
// ram8 -- eight-word by 16-bit register file (Hack RAM8).
//
// Eight 16-bit registers. A 1-to-8 load decoder steers writes to one word.
// An 8-way 16-bit read mux selects the word at `address` onto `y`.
// This is the base tile for the RAM64/RAM512 hierarchy.
//
// Ports:
//   clk      in   1   system clock; writes happen on the rising edge
//   rst      in   1   asynchronous active-high reset; clears all words
//   din      in  16   write data
//   load     in   1   write enable for the word selected by `address`
//   address  in   3   word select, shared by the write and read paths
//   y        out 16   combinational read of word `address`
module ram8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        load,
  input  logic [2:0]  address,
  output logic [15:0] y
);

  logic [15:0] r [8];
  logic [7:0]  ld;

  // Load demux: one line high when load=1, all lines low when load=0.
  always_comb begin
    ld          = '0;
    ld[address] = load;
  end

  // Each word is a Hack register: async clear, otherwise load or hold.
  for (genvar g = 0; g < 8; g++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r[g] <= '0;
      end else if (ld[g]) begin
        r[g] <= din;
      end
    end
  end

  // Read mux. There is no write-through bypass, so a same-address write
  // becomes visible only after the edge.
  always_comb begin
    y = r[address];
  end

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8. A plain array models the eight words.
// Writes are applied to the model when an edge samples load=1 with rst=0.
// Reset clears the model immediately. On every falling edge, y is compared
// with model[address]. Literal expectations from the test plan pin the model.
module tb_ram8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] y;

  int checks = 0;
  int failures = 0;
  bit running = 1'b0;
  logic [15:0] model [8];

  ram8 dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .load(load),
    .address(address),
    .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t addr=%0d)", name, act, exp, $time, address);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // Drive inputs, take one rising edge, and update the model as that edge
  // sampled them. Each call returns 1 time unit after the edge.
  task automatic step(input logic l, input logic [2:0] a, input logic [15:0] d);
    load = l;
    address = a;
    din = d;
    @(posedge clk);
    if (!rst && l) model[a] = d;
    #1;
  endtask

  // Compare process: the read is combinational, so y is meaningful on every
  // cycle. Sampling happens mid-cycle, while the inputs are stable.
  always @(negedge clk) begin
    if (running) chk("y_vs_model", y, model[address]);
  end

  initial begin
    logic [15:0] w;
    clear_model();

    // Reset: sweep every address while rst is high. The load with random
    // data must be ignored.
    #1 rst = 1'b1;
    @(posedge clk);
    #1 running = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'(k), 16'($urandom));
      chk("reset_sweep", y, 16'h0000);
    end
    rst = 1'b0;

    // Walking-one fill, then read back.
    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 16'(1 << k));
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'(k), 16'h0000);
      w = 16'(1 << k);
      chk("walking_one", y, w);
    end

    // Isolation.
    step(1'b1, 3'd5, 16'hBEEF);
    chk("iso_addr5", y, 16'hBEEF);
    step(1'b0, 3'd4, 16'h0000);
    chk("iso_addr4", y, 16'h0010);
    step(1'b0, 3'd6, 16'h0000);
    chk("iso_addr6", y, 16'h0040);
    for (int k = 0; k < 3; k++) step(1'b0, 3'(k + 1), 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 3'(k), 16'hFFFF);
      w = (k == 5) ? 16'hBEEF : 16'(1 << k);
      chk("no_load_hold", y, w);
    end

    // Read during write at address 2.
    load = 1'b1;
    address = 3'd2;
    din = 16'h1234;
    #1 chk("rdw_before", y, 16'h0004);
    @(posedge clk);
    model[2] = 16'h1234;
    #1 chk("rdw_after", y, 16'h1234);

    // Back-to-back loads, same address then different addresses.
    step(1'b1, 3'd7, 16'h1111);
    step(1'b1, 3'd7, 16'h2222);
    step(1'b1, 3'd0, 16'h3333);
    step(1'b1, 3'd1, 16'h4444);
    step(1'b0, 3'd7, 16'h0000);
    chk("last_edge_wins", y, 16'h2222);
    step(1'b0, 3'd0, 16'h0000);
    chk("b2b_addr0", y, 16'h3333);

    // Async reset mid-cycle, with a load held across the next edge.
    address = 3'd5;
    load = 1'b0;
    #2 rst = 1'b1;
    clear_model();
    #1 chk("async_clear", y, 16'h0000);
    load = 1'b1;
    address = 3'd3;
    din = 16'hAAAA;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("load_during_rst", y, 16'h0000);
    step(1'b1, 3'd3, 16'h5A5A);
    chk("first_write_after_rst", y, 16'h5A5A);
    step(1'b0, 3'd5, 16'h0000);
    chk("cleared_addr5", y, 16'h0000);

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b1;
        clear_model();
        #1 rst = 1'b0;
      end
      step(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
    end

    @(negedge clk);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram8.md
# ram8

Eight-word by 16-bit addressable register file (Hack RAM8), the storage stage directly upstream of `mux8way16`. Eight 16-bit registers feed `mux8way16`, which selects the word at `address` onto the read port. A 1-to-8 load demultiplexer steers writes to one register. This block is the base tile for the RAM64/RAM512 hierarchy.

## Interface
- No parameters. Width 16 and depth 8 are fixed by the Hack word and address slice.
- `clk`  input  1  Single system clock. All writes occur on the rising edge.
- `rst`  input  1  Reset, asynchronous and active-high. Clears all eight registers.
- `din`  input  16  Write data.
- `load`  input  1  Write enable for the register selected by `address`.
- `address`  input  3  Word select, shared by the write and read paths.
- `y`  output  16  Read data: the current content of register `address`.

## Operation
- Storage: eight 16-bit registers, r0..r7, each built as a Hack `register` (16 DFFs with a load mux).
- Load steering: a `dmux8way` decodes `load` by `address`.
  - Exactly one register load line is high when `load`=1.
  - All load lines are low when `load`=0.
- Write: on a rising `clk` with `rst`=0 and `load`=1, r[`address`] <= `din`. The other seven registers hold their values.
- Read: `y` = r[`address`] via `mux8way16` (sel = `address`). The read is purely combinational from register state and `address`.
- Reset:
  - When `rst` is asserted, all registers go to 16'h0000 immediately, without waiting for a clock edge.
  - While `rst`=1, `load` is ignored and `y` = 16'h0000 for every `address`.
- Reset deasserting at or near a clock edge: the first write can land no earlier than the first rising edge at which `rst` is sampled low.
- No arithmetic and no width conversion. `din` is stored bit-exact.

## Timing
- Reset value: every register is 16'h0000, so `y` = 16'h0000.
- Write latency is one edge. The value written at edge N is visible on `y` after edge N, as long as `address` still selects that word.
- Read latency is zero cycles. A change on `address` propagates to `y` combinationally within the same cycle.
- Read during write, with `load`=1 and the same `address`:
  - Before the edge, `y` shows the OLD value.
  - After the edge, `y` shows `din`.
  - There is no write-through bypass.
- If `address` changes in the same cycle as a `load`, the write goes to the `address` sampled at the edge.
- Back-to-back loads to the same address: the last edge wins.
- Back-to-back loads to different addresses: each write is independent and none is lost.
- `load`=1 with `din` unchanged rewrites the same value. This is legal and has no side effects.
- Address wrap: all eight codes 3'b000..3'b111 are valid. There is no out-of-range case.
- Async reset mid-operation: asserting `rst` between edges clears all words within the same cycle. A `load` pending for the next edge is discarded if `rst` is still high at that edge.

## Test plan
- Reset: assert `rst` and sweep `address` 0..7 -> `y` = 16'h0000 at every address.
- Walking-one fill:
  - Stimulus: release reset, then for k=0..7 write `din` = 1<<k at `address`=k, one word per edge.
  - Then read 0..7 -> `y` = 16'h0001, 0002, 0004, … 0080.
  - This is the same pattern `mux8way16` is checked with.
- Isolation:
  - Stimulus: after the fill, write 16'hBEEF to address 5.
  - Check: address 5 reads 16'hBEEF. Addresses 4 and 6 still read 16'h0010 and 16'h0040.
  - Check: `load`=0 with `din`=16'hFFFF for 3 edges changes no word.
- Read-during-write:
  - Stimulus: address 2 holds 16'h0004; drive `din`=16'h1234 and `load`=1.
  - Check before the edge: `y`=16'h0004. Check after the edge: `y`=16'h1234.
- Async reset mid-operation:
  - Stimulus: with words populated, pulse `rst` between clock edges.
  - Check: `y` goes to 16'h0000 before the next edge.
  - Check: a `load` held across a reset edge does not write.
  - Check: the first write after `rst` falls lands correctly.
